// File: rtl/xrst_audit_pkg.sv
// Shared constants, field layout and the score-to-compliance mapping for XRST audit records.
// The settlement layer imports the same expected_level() so both sides use one mapping.
package xrst_audit_pkg;

  localparam logic [159:0] REG_TAG      = 160'h524547554C41544F5259;
  localparam logic [7:0]   STATUS_MAGIC = 8'hA5;

  localparam int FIELD_W        = 32;
  localparam int SLA_ID_LSB     = 0;
  localparam int TS_LSB         = 32;
  localparam int SCORE_LSB      = 64;
  localparam int SETTLE_A_LSB   = 96;
  localparam int SETTLE_B_LSB   = 128;
  localparam int SETTLE_C_LSB   = 160;
  localparam int STAKE_LSB      = 192;
  localparam int SLA_STATUS_LSB = 224;
  localparam int PROOF_LSB      = 256;

  localparam logic [31:0] SCORE_TH_HI  = 32'd950;
  localparam logic [31:0] SCORE_TH_MID = 32'd900;
  localparam logic [31:0] SCORE_TH_LO  = 32'd800;

  localparam logic [7:0] LEVEL_HI   = 8'd100;
  localparam logic [7:0] LEVEL_MID  = 8'd90;
  localparam logic [7:0] LEVEL_LO   = 8'd75;
  localparam logic [7:0] LEVEL_BASE = 8'd50;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    STREAM = 2'd2,
    STATUS = 2'd3
  } audit_rd_state_e;

  function automatic logic [7:0] expected_level(input logic [31:0] score);
    logic [7:0] lvl;
    if (score >= SCORE_TH_HI)       lvl = LEVEL_HI;
    else if (score >= SCORE_TH_MID) lvl = LEVEL_MID;
    else if (score >= SCORE_TH_LO)  lvl = LEVEL_LO;
    else                            lvl = LEVEL_BASE;
    return lvl;
  endfunction

endpackage

// File: rtl/xrst_audit_check.sv
// Combinational consistency check of a captured audit record against its hash and
// reported compliance level.
module xrst_audit_check
  import xrst_audit_pkg::*;
(
  input  logic [31:0]  sla_id,
  input  logic [31:0]  timestamp,
  input  logic [31:0]  reliability_score,
  input  logic [255:0] regulatory_hash,
  input  logic [7:0]   compliance_level,
  output logic         hash_ok,
  output logic         level_ok,
  output logic [7:0]   exp_level
);

  // Hash layout: sla_id | timestamp | score | fixed regulator tag in the low 160 bits.
  always_comb begin
    hash_ok = (regulatory_hash[255:224] == sla_id) &&
              (regulatory_hash[223:192] == timestamp) &&
              (regulatory_hash[191:160] == reliability_score) &&
              (regulatory_hash[159:0]   == REG_TAG);
  end

  assign exp_level = expected_level(reliability_score);
  assign level_ok  = (compliance_level == exp_level);

endmodule

// File: rtl/xrst_audit_reader.sv
// Regulator-side audit record reader: accepts one record, checks hash and level,
// then streams the record words plus a status word to the export interface.
//
// state  | meaning
// IDLE   | waiting for a record, rec_ready high
// CHECK  | one cycle: latch hash/level verdicts, bump err_count on failure
// STREAM | presenting record word[index] on the output stream
// STATUS | presenting the status word with out_last
module xrst_audit_reader
  import xrst_audit_pkg::*;
#(
  parameter int RECORD_WORDS = 16,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rec_valid,
  output logic                 rec_ready,
  input  logic [4095:0]        audit_trail,
  input  logic [255:0]         regulatory_hash,
  input  logic [7:0]           compliance_level,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [7:0]           out_index,
  output logic                 hash_ok,
  output logic                 level_ok,
  output logic [31:0]          rec_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int               IDX_W      = $clog2(RECORD_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RECORD_WORDS - 1);
  localparam logic [7:0]       STATUS_IDX = 8'(RECORD_WORDS);

  audit_rd_state_e state_q, state_d;

  logic [31:0]          rec_words [RECORD_WORDS];
  logic [255:0]         hash_q;
  logic [7:0]           level_q;
  logic [7:0]           exp_level_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 hash_ok_q;
  logic                 level_ok_q;
  logic [31:0]          rec_count_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic       chk_hash_ok;
  logic       chk_level_ok;
  logic [7:0] chk_exp_level;
  logic       rec_hs;
  logic       out_hs;

  assign rec_hs = rec_valid && rec_ready;
  assign out_hs = out_valid && out_ready;

  xrst_audit_check u_check (
    .sla_id            (rec_words[SLA_ID_LSB / FIELD_W]),
    .timestamp         (rec_words[TS_LSB / FIELD_W]),
    .reliability_score (rec_words[SCORE_LSB / FIELD_W]),
    .regulatory_hash   (hash_q),
    .compliance_level  (level_q),
    .hash_ok           (chk_hash_ok),
    .level_ok          (chk_level_ok),
    .exp_level         (chk_exp_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rec_hs) state_d = CHECK;
      CHECK:   state_d = STREAM;
      STREAM:  if (out_hs && (idx_q == LAST_IDX)) state_d = STATUS;
      STATUS:  if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rec_ready = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_index = 8'd0;
    out_data  = 32'd0;
    unique case (state_q)
      IDLE: begin
        rec_ready = 1'b1;
        busy      = 1'b0;
      end
      CHECK: ;
      STREAM: begin
        out_valid = 1'b1;
        out_index = 8'(idx_q);
        out_data  = rec_words[idx_q];
      end
      STATUS: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_index = STATUS_IDX;
        out_data  = {STATUS_MAGIC, exp_level_q, rec_count_q[7:0], 5'b0,
                     !level_ok_q, !hash_ok_q, hash_ok_q && level_ok_q};
      end
      default: ;
    endcase
  end

  // Captured payload needs no reset: it is only observable after a handshake.
  always_ff @(posedge clk) begin
    if (rec_hs) begin
      for (int i = 0; i < RECORD_WORDS; i++) rec_words[i] <= audit_trail[32*i +: 32];
      hash_q  <= regulatory_hash;
      level_q <= compliance_level;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      hash_ok_q   <= 1'b0;
      level_ok_q  <= 1'b0;
      exp_level_q <= 8'd0;
      rec_count_q <= 32'd0;
      err_count_q <= '0;
    end else begin
      if (rec_hs) rec_count_q <= rec_count_q + 32'd1;
      if (state_q == CHECK) begin
        hash_ok_q   <= chk_hash_ok;
        level_ok_q  <= chk_level_ok;
        exp_level_q <= chk_exp_level;
        idx_q       <= '0;
        if (!(chk_hash_ok && chk_level_ok) && (err_count_q != '1))
          err_count_q <= err_count_q + 1'b1;
      end
      if ((state_q == STREAM) && out_hs) idx_q <= idx_q + 1'b1;
    end
  end

  assign hash_ok   = hash_ok_q;
  assign level_ok  = level_ok_q;
  assign rec_count = rec_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_xrst_audit_reader.sv
// Self-checking bench for xrst_audit_reader: directed scenarios plus randomized records
// checked against a behavioural model of record checks and the output stream.
module tb_xrst_audit_reader;

  localparam int RW = 16;
  localparam logic [159:0] TAG = 160'h524547554C41544F5259;

  logic          clk = 1'b0;
  logic          rst;
  logic          rec_valid;
  logic          rec_ready;
  logic [4095:0] audit_trail;
  logic [255:0]  regulatory_hash;
  logic [7:0]    compliance_level;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [7:0]    out_index;
  logic          hash_ok;
  logic          level_ok;
  logic [31:0]   rec_count;
  logic [15:0]   err_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  int          m_rec = 0;
  int          m_err = 0;
  logic        m_hok, m_lok;
  logic [7:0]  m_lvl;

  always #5 clk = ~clk;

  xrst_audit_reader #(.RECORD_WORDS(RW), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .audit_trail(audit_trail), .regulatory_hash(regulatory_hash),
    .compliance_level(compliance_level), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_index(out_index),
    .hash_ok(hash_ok), .level_ok(level_ok), .rec_count(rec_count),
    .err_count(err_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_level(input int unsigned s);
    if (s >= 950) return 8'd100;
    if (s >= 900) return 8'd90;
    if (s >= 800) return 8'd75;
    return 8'd50;
  endfunction

  function automatic logic [4095:0] make_trail(input logic [31:0] sla, input logic [31:0] ts,
                                               input logic [31:0] score);
    logic [4095:0] t;
    for (int i = 0; i < 128; i++) t[32*i +: 32] = $urandom;
    t[31:0]  = sla;
    t[63:32] = ts;
    t[95:64] = score;
    return t;
  endfunction

  function automatic logic [255:0] good_hash(input logic [4095:0] t);
    return {t[31:0], t[63:32], t[95:64], TAG};
  endfunction

  task automatic model_accept(input logic [4095:0] t, input logic [255:0] h, input logic [7:0] lv);
    m_rec++;
    m_lvl = ref_level(t[95:64]);
    m_hok = (h == good_hash(t));
    m_lok = (lv == m_lvl);
    if (!(m_hok && m_lok) && m_err < 65535) m_err++;
    exp_q.delete();
    for (int i = 0; i < RW; i++) exp_q.push_back(t[32*i +: 32]);
    exp_q.push_back({8'hA5, m_lvl, 8'(m_rec), 5'b0, !m_lok, !m_hok, m_hok && m_lok});
  endtask

  task automatic send_record(input logic [4095:0] t, input logic [255:0] h, input logic [7:0] lv);
    int w = 0;
    @(negedge clk);
    audit_trail = t; regulatory_hash = h; compliance_level = lv; rec_valid = 1'b1;
    while (!rec_ready && w < 200) begin @(negedge clk); w++; end
    chk("rec_ready_wait", rec_ready, 1);
    @(negedge clk);
    rec_valid = 1'b0;
    model_accept(t, h, lv);
    chk("check_cycle_valid", out_valid, 0);
    chk("check_cycle_ready", rec_ready, 0);
    chk("check_cycle_busy", busy, 1);
  endtask

  // mode 0: always ready, 1: toggle, 2: toggle plus 5-cycle stall on word 7, 3: random
  task automatic run_stream(input int mode);
    int k = 0, cyc = 0, stall_n = 0;
    bit r, prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic [7:0]  prev_i = '0;
    got.delete();
    while (k < RW + 1 && cyc < 1000) begin
      @(negedge clk); cyc++;
      chk("stream_valid", out_valid, 1);
      chk("stream_rec_ready", rec_ready, 0);
      if (prev_stall) begin
        chk("stall_data", out_data, prev_d);
        chk("stall_index", out_index, prev_i);
      end
      case (mode)
        0: r = 1'b1;
        1: r = cyc[0];
        2: if (out_index == 8'd7 && stall_n < 5) begin r = 1'b0; stall_n++; end
           else r = cyc[0];
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = r;
      if (r) begin
        got.push_back(out_data);
        chk("word_data", out_data, exp_q[k]);
        chk("word_index", out_index, k);
        chk("word_last", out_last, k == RW);
        k++;
      end
      prev_stall = !r; prev_d = out_data; prev_i = out_index;
    end
    chk("stream_done", k, RW + 1);
  endtask

  task automatic finish_record();
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_rec_ready", rec_ready, 1);
    chk("post_busy", busy, 0);
    chk("hash_ok", hash_ok, m_hok);
    chk("level_ok", level_ok, m_lok);
    chk("rec_count", rec_count, m_rec);
    chk("err_count", err_count, m_err);
  endtask

  initial begin
    logic [4095:0] t, tb2;
    logic [255:0]  h;
    logic [7:0]    lv;
    int            hs[2];
    int            n, cyc, w;
    bit            switched;
    int unsigned   score_pool[9];

    rst = 1'b1; rec_valid = 1'b0; out_ready = 1'b0;
    audit_trail = '0; regulatory_hash = '0; compliance_level = '0;
    repeat (3) @(negedge clk);
    chk("rst_rec_ready", rec_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_hash_ok", hash_ok, 0);
    chk("rst_level_ok", level_ok, 0);
    chk("rst_rec_count", rec_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // good record
    t = make_trail(32'h1234, 32'h100, 32'd960);
    send_record(t, good_hash(t), 8'd100);
    run_stream(0);
    chk("good_word0", got[0], 32'h1234);
    chk("good_word2", got[2], 32'd960);
    chk("good_status", got[RW], 32'hA5640101);
    finish_record();

    // level mismatch
    t = make_trail(32'hBEEF, 32'h200, 32'd850);
    send_record(t, good_hash(t), 8'd90);
    run_stream(0);
    chk("lvl_status_lo", got[RW][7:0], 8'h04);
    chk("lvl_status_exp", got[RW][23:16], 8'h4B);
    finish_record();
    chk("lvl_err_count", err_count, 1);

    // hash corruption
    t = make_trail(32'h77, 32'h300, 32'd900);
    h = good_hash(t); h[0] = ~h[0];
    send_record(t, h, 8'd90);
    run_stream(0);
    chk("hash_status_lo", got[RW][7:0], 8'h02);
    finish_record();
    chk("hash_err_count", err_count, 2);

    // backpressure
    t = make_trail(32'h4242, 32'h400, 32'd800);
    send_record(t, good_hash(t), 8'd75);
    run_stream(2);
    finish_record();

    // back-to-back
    t   = make_trail(32'h5, 32'h6, 32'd955);
    tb2 = make_trail(32'h7, 32'h8, 32'd910);
    out_ready = 1'b1;
    @(negedge clk);
    audit_trail = t; regulatory_hash = good_hash(t); compliance_level = 8'd100; rec_valid = 1'b1;
    n = 0; cyc = 0; switched = 1'b0;
    while (n < 2 && cyc < 200) begin
      if (rec_ready) begin
        hs[n] = cyc; n++;
        if (n == 1) model_accept(t, good_hash(t), 8'd100);
      end
      @(negedge clk); cyc++;
      out_ready = 1'b1;
      if (n == 1 && !switched) begin
        audit_trail = tb2; regulatory_hash = good_hash(tb2); compliance_level = 8'd90;
        switched = 1'b1;
      end
    end
    rec_valid = 1'b0;
    chk("b2b_handshakes", n, 2);
    chk("b2b_gap", hs[1] - hs[0], RW + 3);
    model_accept(tb2, good_hash(tb2), 8'd90);
    chk("b2b_check_valid", out_valid, 0);
    run_stream(0);
    finish_record();
    chk("b2b_rec_count", rec_count, 6);

    // reset mid-stream, with a failing record so err_count is non-zero beforehand
    t = make_trail(32'h99, 32'h500, 32'd700);
    h = good_hash(t); h[200] = ~h[200];
    send_record(t, h, 8'd50);
    out_ready = 1'b1; w = 0;
    while (out_index != 8'd5 && w < 100) begin @(negedge clk); w++; end
    chk("reached_word5", out_index, 5);
    rst = 1'b1;
    @(negedge clk);
    m_rec = 0; m_err = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rec_ready", rec_ready, 1);
    chk("mid_rst_rec_count", rec_count, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0; out_ready = 1'b0;
    t = make_trail(32'hABCD, 32'h600, 32'd1000);
    send_record(t, good_hash(t), 8'd100);
    run_stream(1);
    finish_record();

    // randomized records around the score thresholds
    score_pool = '{949, 950, 899, 900, 799, 800, 0, 1100, 0};
    for (int r = 0; r < 8; r++) begin
      int unsigned sc;
      int unsigned pick;
      pick = $urandom_range(0, 8);
      sc = (pick == 8) ? $urandom_range(0, 2000) : score_pool[pick];
      t = make_trail($urandom, $urandom, sc);
      h = good_hash(t);
      if ($urandom_range(0, 3) == 0) begin
        int unsigned b;
        b = $urandom_range(0, 255);
        h[b] = ~h[b];
      end
      lv = ref_level(sc);
      if ($urandom_range(0, 3) == 0) lv = 8'($urandom_range(0, 255));
      send_record(t, h, lv);
      run_stream(3);
      finish_record();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xrst_audit_reader.md
Name: xrst_audit_reader

Overview:
Regulator-side consumer of XRST settlement audit records. It accepts one audit_trail record with its regulatory_hash and compliance_level over a valid/ready handshake, then re-derives and checks the hash layout and the score-to-compliance mapping. It streams the record as 32-bit words, followed by one status word, to the regulator export interface. It sits downstream of the settlement layer, ahead of the regulator-facing DMA/UART bridge.

Parameters:
RECORD_WORDS, 16, number of 32-bit words of audit_trail streamed, taken from bit 0 upward; legal range 8..128.
ERR_CNT_W, 16, width of the saturating error counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rec_valid  input  1  record presented
rec_ready  output  1  record accepted when rec_valid && rec_ready
audit_trail  input  4096  packed record: [31:0] sla_id, [63:32] timestamp, [95:64] reliability_score, [127:96]/[159:128]/[191:160] settlement a/b/c, [223:192] remaining_stake, [255:224] sla_status, [511:256] compliance_proof
regulatory_hash  input  256  hash accompanying the record
compliance_level  input  8  level reported by the settlement layer
out_data  output  32  stream word
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts
out_last  output  1  marks the status word
out_index  output  8  index of the current word (0..RECORD_WORDS)
hash_ok  output  1  last record's hash consistent
level_ok  output  1  last record's level consistent
rec_count  output  32  records accepted
err_count  output  ERR_CNT_W  records that failed any check (saturating)
busy  output  1  state != IDLE

Behaviour:
- Reset (rst high at a clk edge) takes priority over everything:
  - state = IDLE; all outputs 0 except rec_ready = 1.
  - Reset mid-stream drops out_valid on the next cycle; the partial record is discarded and is not counted in err_count.
- FSM states:
  - IDLE: rec_ready = 1. On handshake, capture audit_trail[32*RECORD_WORDS-1:0], regulatory_hash and compliance_level; increment rec_count (wraps at 2^32); go to CHECK.
  - CHECK, exactly 1 cycle:
    - hash_ok = hash[255:224]==sla_id && hash[223:192]==timestamp && hash[191:160]==reliability_score && hash[159:0]==160'h524547554C41544F5259 (zero-extended).
    - Expected level from reliability_score (unsigned): >=950 gives 100, >=900 gives 90, >=800 gives 75, else 50.
    - level_ok = (captured level == expected).
    - If either check fails, err_count increments, saturating at all-ones.
    - Go to STREAM with index = 0.
  - STREAM: out_valid = 1 and out_data = captured word[index].
    - On out_valid && out_ready, index increments; after word RECORD_WORDS-1 is accepted, go to STATUS.
  - STATUS: out_valid = 1, out_last = 1, out_index = RECORD_WORDS.
    - out_data = {8'hA5, expected_level, rec_count[7:0], 5'b0, !level_ok, !hash_ok, hash_ok&&level_ok}.
    - On handshake go to IDLE.
- Latency: handshake at cycle N, first out_valid at N+2; minimum record period is RECORD_WORDS+3 cycles with out_ready held high.
- AXI-style stream rules:
  - out_data, out_last and out_index stay stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- rec_ready is 0 outside IDLE; no record is ever captured while busy.
- hash_ok and level_ok update in CHECK and hold until the next CHECK.
- out_ready asserted while out_valid is low has no effect.

Decomposition:
- Package xrst_audit_pkg holds:
  - REG_TAG (160'h524547554C41544F5259) and STATUS_MAGIC (8'hA5);
  - field offset localparams (SLA_ID_LSB=0, TS_LSB=32, SCORE_LSB=64, ...);
  - score thresholds (950/900/800) and their levels (100/90/75/50);
  - enum audit_rd_state_e {IDLE, CHECK, STREAM, STATUS};
  - function expected_level(score), shared with the settlement layer so the mapping has one source.
- One natural sub-module, xrst_audit_check: combinational hash and level comparison on the captured record; returns hash_ok, level_ok and expected_level.

Test Plan:
- Good record: sla_id=0x1234, ts=0x100, score=960, correct hash, level=100, out_ready=1 -> 16 data words (word0=0x1234, word2=960), then status 0xA5_64_01_01 with out_last; hash_ok=level_ok=1; rec_count=1; err_count=0.
- Level mismatch: score=850, level=90 -> level_ok=0, hash_ok=1; status low byte 0x04, byte2=75 (0x4B); err_count increments.
- Hash corruption: hash[0] flipped -> hash_ok=0; status low byte 0x02; err_count increments.
- Backpressure: out_ready toggled 1/0 every cycle, plus a 5-cycle stall on word 7 -> out_data constant during stalls; all 17 words delivered in order; rec_ready stays 0 until the status handshake.
- Back-to-back: rec_valid held high with out_ready=1 -> second handshake exactly RECORD_WORDS+3 cycles after the first; rec_count=2.
- Reset mid-stream: rst asserted at word 5 -> next cycle out_valid=0, rec_ready=1, rec_count=0, err_count=0; a subsequent record streams from word 0.
